alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Command-driven front end for the 8-bit add/xor/nand ALU datapath.
- Accepts register-level commands on a valid/ready interface and holds a 4-entry x 8-bit register file.
- Drives the ALU's opcode, a and b inputs, captures the ALU's out, writes the result back to the register file, and returns it on a valid/ready response interface.
- Sits between the command source (testbench or future decoder) and the combinational ALU instance, which is external to this block.

Parameters:
- DATA_W, 8, operand/result width; fixed to match the ALU.
- REG_AW, 2, register-file address width (4 registers).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  2  00 add, 01 xor, 10 nand, 11 load-immediate.
- cmd_dst  input  REG_AW  destination register.
- cmd_src_a  input  REG_AW  operand A register.
- cmd_src_b  input  REG_AW  operand B register.
- cmd_imm  input  DATA_W  immediate, used only by load.
- alu_opcode  output  2  to the ALU opcode input.
- alu_a  output  DATA_W  to ALU a.
- alu_b  output  DATA_W  to ALU b.
- alu_out  input  DATA_W  from ALU out.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  DATA_W  value written to cmd_dst.
- rsp_dst  output  REG_AW  register that was written.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; all four registers, alu_opcode, alu_a, alu_b, rsp_data and rsp_dst = 0.
  - rsp_valid=0; cmd_ready=0 while rst_n is low.
- States are IDLE, EXEC and RESP.
- IDLE:
  - cmd_ready=1; rsp_valid=0.
  - Accept occurs on the clock edge where cmd_valid & cmd_ready.
  - On accept, register alu_opcode<=cmd_op, alu_a<=reg[cmd_src_a], alu_b<=reg[cmd_src_b], and latch cmd_dst, cmd_op and cmd_imm; go to EXEC.
- EXEC (one cycle):
  - cmd_ready=0. ALU inputs are stable for the full cycle.
  - At the end of the cycle: result = cmd_imm if op=11, else alu_out.
  - Write reg[dst]<=result, rsp_data<=result, rsp_dst<=dst, rsp_valid<=1; go to RESP.
- RESP:
  - cmd_ready=0. rsp_valid, rsp_data and rsp_dst are held stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid<=0; go to IDLE.
- Latency: command accepted on edge k gives rsp_valid high after edge k+1. Maximum throughput is one command per 3 cycles.
- Write-before-read: the register write completes before IDLE is re-entered, so a following command always reads the updated value. No forwarding is needed.
- Registers are read at accept time, so src_a == src_b == dst is legal and uses old values.
- Arithmetic:
  - add is modulo 2^8; carry is discarded.
  - Results are taken from alu_out unmodified; this block performs no computation itself except for load.
- Load: alu_opcode is still driven to 2'b11 (the ALU result is ignored); the imm value is written.
- alu_* outputs hold their last value outside EXEC.
- cmd_* inputs are ignored when cmd_ready=0.
- rsp_ready is ignored when rsp_valid=0.
- Reset mid-operation (EXEC or RESP):
  - The command is abandoned; no register write occurs if reset is asserted before the EXEC edge.
  - rsp_valid drops immediately.
  - All state returns to reset values.

Test Plan:
- Load/add: LOAD r0=0x3C, LOAD r1=0xA5, ADD r2=r0+r1 -> rsp_data=0xE1, rsp_dst=2; rsp_valid one edge after the EXEC cycle; alu_opcode=00, alu_a=0x3C, alu_b=0xA5 during EXEC.
- XOR/NAND: XOR r3=r0^r1 -> 0x99; NAND r2=r0,r1 -> 0xDB; alu_opcode=01 and 10 respectively.
- Wrap and aliasing:
  - LOAD r0=0xFF, LOAD r1=0x02, ADD r0=r0+r1 -> 0x01.
  - Then ADD r1=r1+r1 -> 0x04, using the old values.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data and rsp_dst stable; cmd_ready=0 with cmd_valid=1 and no new accept.
  - rsp_ready=1 -> IDLE next cycle; the pending command is accepted on the following edge.
- Back-to-back dependency: ADD r2=r0+r1 followed immediately by XOR r3=r2^r2 -> second rsp_data=0x00; ADD r3=r2+r0 reads the new r2.
- Reset mid-EXEC:
  - r2=0x11, issue LOAD r2=0x77, pulse rst_n low during EXEC -> rsp_valid=0 immediately; all registers 0 afterwards; cmd_ready=1 after release.
  - Subsequent ADD r0=r2+r2 -> 0x00.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: command front end for the external 8-bit add/xor/nand ALU.
// Holds a small register file, drives the ALU operands and returns results.
module alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_dst,
  input  logic [REG_AW-1:0] cmd_src_a,
  input  logic [REG_AW-1:0] cmd_src_b,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [1:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [REG_AW-1:0] rsp_dst
);

  localparam int NREG = 1 << REG_AW;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef struct packed {
    logic [1:0]        op;
    logic [REG_AW-1:0] dst;
    logic [DATA_W-1:0] imm;
  } cmd_t;

  state_t            state;
  state_t            state_nxt;
  cmd_t              cur;
  logic [DATA_W-1:0] rf [NREG];
  logic [DATA_W-1:0] result;
  logic              accept;
  logic              exec_wr;
  logic              rsp_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    exec_wr   = 1'b0;
    rsp_fire  = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = rst_n;
        accept    = cmd_valid & rst_n;
        if (accept) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        exec_wr   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_fire  = rsp_ready;
        if (rsp_fire) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Load bypasses the ALU; everything else passes alu_out through untouched.
  always_comb begin
    result = alu_out;
    unique case (1'b1)
      (cur.op == OP_LOAD): result = cur.imm;
      default:             result = alu_out;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      cur        <= '0;
      rsp_data   <= '0;
      rsp_dst    <= '0;
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (accept) begin
        alu_opcode <= cmd_op;
        alu_a      <= rf[cmd_src_a];
        alu_b      <= rf[cmd_src_b];
        cur.op     <= cmd_op;
        cur.dst    <= cmd_dst;
        cur.imm    <= cmd_imm;
      end
      // Write lands before IDLE, so the next command sees it.
      if (exec_wr) begin
        rf[cur.dst] <= result;
        rsp_data    <= result;
        rsp_dst     <= cur.dst;
      end
    end
  end

endmodule
